encdec_ctrl: RTL and testbench

- APB-slave register file and sequencing FSM for the encoder/decoder datapath.
- Software programs operation, codeword width, data and noise, then writes CTRL. The block issues one start to the datapath, waits for its valid, and captures result and error count.
- It presents the captured values on data_out / num_of_errors with a single-cycle operation_done pulse, the same signals the golden model checks against.

---
 rtl/encdec_ctrl.sv | 148 ++++++++++++++
 tb/tb_encdec_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/encdec_ctrl.sv
// encdec_ctrl: APB register file plus sequencer for the encoder/decoder datapath.
// Software writes operation, width, data and noise. A CTRL write then issues one
// start pulse. The block waits for the datapath result, or for a timeout, and
// presents the result with a single-cycle operation_done pulse.
module encdec_ctrl #(
  parameter int DATA_WIDTH      = 32,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int AMBA_WORD       = 32,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  input  logic                       PENABLE,
  input  logic                       PSEL,
  input  logic [AMBA_WORD-1:0]       PWDATA,
  input  logic                       PWRITE,
  output logic [AMBA_WORD-1:0]       PRDATA,
  output logic                       dp_start,
  output logic [1:0]                 dp_op,
  output logic [1:0]                 dp_width,
  output logic [DATA_WIDTH-1:0]      dp_data,
  output logic [DATA_WIDTH-1:0]      dp_noise,
  input  logic                       dp_valid,
  input  logic [DATA_WIDTH-1:0]      dp_data_out,
  input  logic [1:0]                 dp_num_of_errors,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic [1:0]                 num_of_errors,
  output logic                       operation_done,
  output logic                       busy
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t                state, state_nxt;
  logic [1:0]            ctrl_q, width_q;
  logic [DATA_WIDTH-1:0] data_q, noise_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [1:0]            reg_sel;
  logic                  reg_wr, start_req, timeout, capture;
  logic                  unused_paddr;

  // Only bits [3:2] decode a register; the remaining address bits alias.
  assign unused_paddr = ^{PADDR[AMBA_ADDR_WIDTH-1:4], PADDR[1:0]};
  assign reg_sel      = PADDR[3:2];

  // Writes are accepted only in IDLE, so dp_* cannot change mid-operation.
  assign reg_wr    = PSEL & PENABLE & PWRITE & (state == S_IDLE);
  assign start_req = reg_wr && (reg_sel == 2'd0) && (PWDATA[1:0] != 2'b11)
                     && (width_q != 2'b11);
  assign timeout   = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign capture   = (state == S_WAIT) && (dp_valid || timeout);

  assign dp_op    = ctrl_q;
  assign dp_width = width_q;
  assign dp_data  = data_q;
  assign dp_noise = noise_q;

  // Software-visible registers.
  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q  <= '0;
      width_q <= '0;
      data_q  <= '0;
      noise_q <= '0;
    end else if (reg_wr) begin
      case (reg_sel)
        2'd0:    ctrl_q  <= PWDATA[1:0];
        2'd1:    data_q  <= PWDATA[DATA_WIDTH-1:0];
        2'd2:    width_q <= PWDATA[1:0];
        default: noise_q <= PWDATA[DATA_WIDTH-1:0];
      endcase
    end
  end

  // Combinational read mux; the bus is driven only during a read access.
  always_comb begin
    PRDATA = '0;
    if (PSEL && !PWRITE) begin
      case (reg_sel)
        2'd0:    PRDATA = AMBA_WORD'(ctrl_q);
        2'd1:    PRDATA = AMBA_WORD'(data_q);
        2'd2:    PRDATA = AMBA_WORD'(width_q);
        default: PRDATA = AMBA_WORD'(noise_q);
      endcase
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic and per-state strobes.
  // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_nxt      = state;
    dp_start       = 1'b0;
    operation_done = 1'b0;
    busy           = 1'b1;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start_req) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        dp_start  = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (capture) state_nxt = S_DONE;
      end
      S_DONE: begin
        operation_done = 1'b1;
        state_nxt      = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Timeout counter: cleared while issuing, counts each WAIT cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  cnt_q <= '0;
    else if (state == S_ISSUE) cnt_q <= '0;
    else if (state == S_WAIT)  cnt_q <= cnt_q + 1'b1;
  end

  // Result capture; a valid in the expiry cycle takes priority over the timeout code.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out      <= '0;
      num_of_errors <= '0;
    end else if (capture) begin
      if (dp_valid) begin
        data_out      <= dp_data_out;
        num_of_errors <= dp_num_of_errors;
      end else begin
        data_out      <= '0;
        num_of_errors <= 2'b11;
      end
    end
  end

endmodule

// File: tb/tb_encdec_ctrl.sv
// Self-checking bench for encdec_ctrl: register table, directed sequences,
// randomized operations against a transaction-level reference model.
module tb_encdec_ctrl;

  localparam int DW = 32;
  localparam int AW = 20;
  localparam int WW = 32;
  localparam int TC = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] PADDR = '0;
  logic          PENABLE = 1'b0;
  logic          PSEL = 1'b0;
  logic [WW-1:0] PWDATA = '0;
  logic          PWRITE = 1'b0;
  logic [WW-1:0] PRDATA;
  logic          dp_start;
  logic [1:0]    dp_op, dp_width;
  logic [DW-1:0] dp_data, dp_noise;
  logic          dp_valid = 1'b0;
  logic [DW-1:0] dp_data_out = '0;
  logic [1:0]    dp_num_of_errors = '0;
  logic [DW-1:0] data_out;
  logic [1:0]    num_of_errors;
  logic          operation_done, busy;

  encdec_ctrl #(
    .DATA_WIDTH(DW), .AMBA_ADDR_WIDTH(AW), .AMBA_WORD(WW), .TIMEOUT_CYCLES(TC)
  ) dut (
    .clk(clk), .rst(rst), .PADDR(PADDR), .PENABLE(PENABLE), .PSEL(PSEL),
    .PWDATA(PWDATA), .PWRITE(PWRITE), .PRDATA(PRDATA), .dp_start(dp_start),
    .dp_op(dp_op), .dp_width(dp_width), .dp_data(dp_data), .dp_noise(dp_noise),
    .dp_valid(dp_valid), .dp_data_out(dp_data_out),
    .dp_num_of_errors(dp_num_of_errors), .data_out(data_out),
    .num_of_errors(num_of_errors), .operation_done(operation_done), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int start_total = 0;
  int done_total  = 0;

  // Reference model: register contents and last presented result.
  logic [1:0]    m_ctrl, m_width, m_err;
  logic [DW-1:0] m_data, m_noise, m_out;

  always @(negedge clk) begin
    if (dp_start)       start_total++;
    if (operation_done) done_total++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_ctrl = '0; m_width = '0; m_err = '0;
    m_data = '0; m_noise = '0; m_out = '0;
  endtask

  task automatic apb_write(input logic [AW-1:0] a, input logic [WW-1:0] d);
    @(negedge clk);
    PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = a; PWDATA = d;
    @(negedge clk);
    PENABLE = 1'b1;
    @(posedge clk);
    #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [AW-1:0] a, output logic [WW-1:0] d);
    @(negedge clk);
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = a;
    #1;
    d = PRDATA;
    PSEL = 1'b0;
  endtask

  // Register write while idle, mirrored into the model.
  task automatic reg_write(input logic [AW-1:0] a, input logic [WW-1:0] d);
    apb_write(a, d);
    case (a[3:2])
      2'd0:    m_ctrl  = d[1:0];
      2'd1:    m_data  = d;
      2'd2:    m_width = d[1:0];
      default: m_noise = d;
    endcase
  endtask

  // Write CTRL=op, then answer with dp_valid 'delay' cycles after the write edge
  // (cycle 0 is the one right after that edge). Optionally try a DATA_IN write
  // in cycle 2 while the block should be busy.
  task automatic run_op(input string tag, input logic [1:0] op, input int delay,
                        input logic [DW-1:0] resp, input logic [1:0] resp_err,
                        input bit busy_wr, input logic [WW-1:0] bw_data);
    int starts, dones, start_k, done_k, exp_done_k;
    logic [DW-1:0] done_data;
    logic [1:0] done_err;
    logic [WW-1:0] w, rd;
    bit legal, hit;
    w = $urandom;
    w[1:0] = op;
    apb_write('0, w);
    m_ctrl = op;
    legal = (op != 2'b11) && (m_width != 2'b11);
    starts = 0; dones = 0; start_k = -1; done_k = -1;
    done_data = '0; done_err = '0;
    for (int k = 0; k <= TC + 4; k++) begin
      dp_valid         = (k == delay);
      dp_data_out      = (k == delay) ? resp : DW'($urandom);
      dp_num_of_errors = (k == delay) ? resp_err : 2'($urandom);
      if (busy_wr && k == 2) begin
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 'h4; PWDATA = bw_data;
      end else begin
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
      end
      @(negedge clk);
      if (dp_start) begin starts++; start_k = k; end
      if (operation_done) begin
        dones++; done_k = k; done_data = data_out; done_err = num_of_errors;
      end
      @(posedge clk);
      #1;
    end
    dp_valid = 1'b0;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;

    // ISSUE in cycle 0, WAIT in cycles 1..TC, DONE one cycle after the deciding WAIT cycle.
    hit = legal && delay >= 1 && delay <= TC;
    exp_done_k = hit ? delay + 1 : TC + 1;
    if (legal) begin
      m_out = hit ? resp : '0;
      m_err = hit ? resp_err : 2'b11;
    end

    check({tag, "_starts"}, starts, legal ? 1 : 0);
    check({tag, "_dones"}, dones, legal ? 1 : 0);
    if (legal) begin
      check({tag, "_start_cycle"}, start_k, 0);
      check({tag, "_done_cycle"}, done_k, exp_done_k);
      check({tag, "_done_result"}, {done_data, done_err}, {m_out, m_err});
    end
    check({tag, "_held_result"}, {data_out, num_of_errors}, {m_out, m_err});
    check({tag, "_busy_end"}, busy, 1'b0);
    check({tag, "_dp_regs"}, {dp_op, dp_width, dp_data, dp_noise},
          {m_ctrl, m_width, m_data, m_noise});
    apb_read('h0, rd);
    check({tag, "_ctrl_rd"}, rd, WW'(m_ctrl));
  endtask

  typedef struct {
    logic [AW-1:0] waddr;
    logic [WW-1:0] wdata;
    logic [AW-1:0] raddr;
    logic [WW-1:0] exp;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [WW-1:0] rd;
    int d0;

    // Reset: outputs must be zero even with a read access and write attempt pending.
    model_reset();
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = '0; PWDATA = '1;
    #13;
    PWRITE = 1'b0;
    #4;
    check("reset_outputs",
          {PRDATA, dp_start, dp_op, dp_width, dp_data, dp_noise, data_out,
           num_of_errors, operation_done, busy}, '0);
    PSEL = 1'b0; PENABLE = 1'b0;
    #5 rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      apb_read(AW'(i * 4), rd);
      check($sformatf("reset_read_%0d", i), rd, '0);
    end

    // Register write/readback table, including aliases and masked fields.
    vecs[0] = '{'h00004, 32'hDEAD_BEEF, 'h00004, 32'hDEAD_BEEF};
    vecs[1] = '{'h0000C, 32'h1234_5678, 'h0000C, 32'h1234_5678};
    vecs[2] = '{'h00008, 32'hFFFF_FFFE, 'h00008, 32'h0000_0002};
    vecs[3] = '{'h00008, 32'h0000_0007, 'h00008, 32'h0000_0003};
    vecs[4] = '{'h00000, 32'hA5A5_0003, 'h00000, 32'h0000_0003};
    vecs[5] = '{'h00008, 32'hFFFF_FFF1, 'h00038, 32'h0000_0001};
    vecs[6] = '{'hFFF04, 32'h0BAD_F00D, 'h00004, 32'h0BAD_F00D};
    vecs[7] = '{'h0001C, 32'hCAFE_0000, 'h0000C, 32'hCAFE_0000};
    vecs[8] = '{'h00008, 32'h0000_0000, 'h00008, 32'h0000_0000};
    for (int i = 0; i < 9; i++) begin
      reg_write(vecs[i].waddr, vecs[i].wdata);
      apb_read(vecs[i].raddr, rd);
      check($sformatf("table_%0d", i), rd, vecs[i].exp);
    end
    check("table_no_start", start_total, 0);
    check("table_dp_regs", {dp_op, dp_width, dp_data, dp_noise},
          {m_ctrl, m_width, m_data, m_noise});

    // Encode, width 8, datapath answers 3 cycles after the start pulse.
    reg_write('hC, 32'h0);
    reg_write('h4, 32'h0000_00A5);
    reg_write('h8, 32'h0);
    run_op("enc8", 2'b00, 3, 32'h0000_5A3C, 2'b00, 1'b0, '0);

    // Full channel, width 32, one noise bit; DATA_IN write while busy is dropped.
    reg_write('h8, 32'h2);
    reg_write('h4, 32'h1234_5678);
    reg_write('hC, 32'h0000_0010);
    run_op("full32", 2'b10, 3, 32'h1234_5678, 2'b01, 1'b1, 32'hFFFF_FFFF);
    apb_read('h4, rd);
    check("busy_write_ignored", rd, 32'h1234_5678);

    // Timeout with no valid, then valid in the last WAIT cycle.
    run_op("timeout", 2'b01, TC + 3, 32'h1111_1111, 2'b10, 1'b0, '0);
    run_op("timeout_last", 2'b01, TC, 32'hCAFE_BABE, 2'b10, 1'b0, '0);

    // Valid while issuing is ignored; the operation then times out.
    run_op("valid_in_issue", 2'b00, 0, 32'h7777_7777, 2'b01, 1'b0, '0);

    // Illegal operation and illegal width.
    run_op("illegal_op", 2'b11, 2, 32'h5555_5555, 2'b01, 1'b0, '0);
    reg_write('h8, 32'h3);
    run_op("illegal_width", 2'b00, 2, 32'h5555_5555, 2'b01, 1'b0, '0);
    reg_write('h8, 32'h1);

    // Randomized operations.
    for (int i = 0; i < 24; i++) begin
      reg_write('h4, $urandom);
      reg_write('hC, $urandom);
      reg_write('h8, ($urandom_range(0, 7) == 0) ? 32'h3 : WW'($urandom_range(0, 2)));
      run_op($sformatf("rand%0d", i), 2'($urandom_range(0, 3)), $urandom_range(0, TC + 2),
             DW'($urandom), 2'($urandom), 1'b0, '0);
    end

    // Reset in the middle of WAIT, then a late valid.
    reg_write('h8, 32'h0);
    apb_write('h0, 32'h0);
    m_ctrl = 2'b00;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    #1 rst = 1'b1;
    model_reset();
    d0 = done_total;
    @(posedge clk);
    #1;
    dp_valid = 1'b1; dp_data_out = 32'h9999_9999; dp_num_of_errors = 2'b01;
    @(posedge clk);
    #1;
    dp_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_no_done", done_total, d0);
    check("rst_mid_result", {data_out, num_of_errors}, {m_out, m_err});
    apb_read('h0, rd);
    check("rst_mid_ctrl", rd, WW'(m_ctrl));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
